clk_div_fwd: RTL and testbench

//   Clock-support block for the readout board's clock tree; one clock domain (CLK).
//   - Integer clock divider: produces a CE strobe and a divided CLOCK.

---
 rtl/clk_div_fwd.sv | 96 +++++++++
 tb/tb_clk_div_fwd.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_fwd.sv
// Clock-support block: integer divider (CE strobe + divided clock), ODDR-style
// forwarding cell, and a LOCKED flag that rises a fixed time after reset release.
module clk_div_fwd #(
  parameter int DIVISOR     = 8,
  parameter int LOCK_CYCLES = 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic DIV_CLR,
  output logic CE,
  output logic CLOCK,
  input  logic D1,
  input  logic D2,
  input  logic DDR_CE,
  input  logic DDR_R,
  input  logic DDR_S,
  output logic Q,
  output logic LOCKED
);

  localparam int CNT_W  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(DIVISOR / 2);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ce_q, ce_d;
  logic              clock_q, clock_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              locked_q, locked_d;
  logic              d1_q, d1_d;
  logic              d2_q, d2_d;
  logic              d2n_q, d2n_d;
  logic              cnt_wrap;

  always_comb begin
    cnt_wrap = (cnt_q == CNT_LAST);
    cnt_d    = (DIV_CLR || cnt_wrap) ? '0 : cnt_q + 1'b1;
    ce_d     = cnt_wrap && !DIV_CLR;
    // High phase covers the first DIVISOR/2 counts, so odd ratios stretch the low phase.
    clock_d  = (cnt_q < CNT_HALF) && !DIV_CLR;

    lock_cnt_d = (lock_cnt_q == LOCK_LAST) ? lock_cnt_q : lock_cnt_q + 1'b1;
    locked_d   = (lock_cnt_d == LOCK_LAST);

    d1_d = d1_q;
    d2_d = d2_q;
    if (DDR_R) begin
      d1_d = 1'b0;
      d2_d = 1'b0;
    end else if (DDR_S) begin
      d1_d = 1'b1;
      d2_d = 1'b1;
    end else if (DDR_CE) begin
      d1_d = D1;
      d2_d = D2;
    end
    d2n_d = d2_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q      <= '0;
      ce_q       <= 1'b0;
      clock_q    <= 1'b0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      d1_q       <= 1'b0;
      d2_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ce_q       <= ce_d;
      clock_q    <= clock_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
    end
  end

  // Low-phase data is retimed onto the falling edge so it cannot glitch into the high phase.
  always_ff @(negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      d2n_q <= 1'b0;
    end else begin
      d2n_q <= d2n_d;
    end
  end

  assign Q      = CLK ? d1_q : d2n_q;
  assign CE     = ce_q;
  assign CLOCK  = clock_q;
  assign LOCKED = locked_q;

endmodule

// File: tb/tb_clk_div_fwd.sv
// Randomized self-checking bench for clk_div_fwd: three instances (DIVISOR 8/3/1)
// share stimulus and are checked against an edge-counting reference model.
module tb_clk_div_fwd;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic DIV_CLR = 1'b0;
  logic D1 = 1'b0, D2 = 1'b0, DDR_CE = 1'b0, DDR_R = 1'b0, DDR_S = 1'b0;
  logic ce8, clk8, q8, lk8;
  logic ce3, clk3, q3, lk3;
  logic ce1, clk1, q1, lk1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  clk_div_fwd #(.DIVISOR(8), .LOCK_CYCLES(16)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .DIV_CLR(DIV_CLR), .CE(ce8), .CLOCK(clk8),
    .D1(D1), .D2(D2), .DDR_CE(DDR_CE), .DDR_R(DDR_R), .DDR_S(DDR_S),
    .Q(q8), .LOCKED(lk8));

  clk_div_fwd #(.DIVISOR(3), .LOCK_CYCLES(5)) u_div3 (
    .CLK(CLK), .RST_N(RST_N), .DIV_CLR(DIV_CLR), .CE(ce3), .CLOCK(clk3),
    .D1(D1), .D2(D2), .DDR_CE(DDR_CE), .DDR_R(DDR_R), .DDR_S(DDR_S),
    .Q(q3), .LOCKED(lk3));

  clk_div_fwd #(.DIVISOR(1), .LOCK_CYCLES(1)) u_div1 (
    .CLK(CLK), .RST_N(RST_N), .DIV_CLR(DIV_CLR), .CE(ce1), .CLOCK(clk1),
    .D1(D1), .D2(D2), .DDR_CE(DDR_CE), .DDR_R(DDR_R), .DDR_S(DDR_S),
    .Q(q1), .LOCKED(lk1));

  // Reference model: edges since the last reset/clear, edges since reset, and the
  // values the DDR output should show in each clock phase.
  int e_edges = 0;
  int lock_n = 0;
  bit m_hi = 1'b0, m_lo_next = 1'b0, m_lo = 1'b0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      e_edges <= 0; lock_n <= 0; m_hi <= 1'b0; m_lo_next <= 1'b0;
    end else begin
      e_edges <= DIV_CLR ? 0 : e_edges + 1;
      lock_n  <= lock_n + 1;
      if (DDR_R) begin
        m_hi <= 1'b0; m_lo_next <= 1'b0;
      end else if (DDR_S) begin
        m_hi <= 1'b1; m_lo_next <= 1'b1;
      end else if (DDR_CE) begin
        m_hi <= D1; m_lo_next <= D2;
      end
    end
  end

  always @(negedge CLK or negedge RST_N) begin
    if (!RST_N) m_lo <= 1'b0;
    else        m_lo <= m_lo_next;
  end

  function automatic bit clk_of(int e, int div);
    return (e != 0) && (((e - 1) % div) < (div / 2));
  endfunction

  function automatic bit ce_of(int e, int div);
    return (e != 0) && ((e % div) == 0);
  endfunction

  function automatic logic [11:0] expv(bit hi);
    bit qe;
    qe = hi ? m_hi : m_lo;
    return {ce_of(e_edges, 8), clk_of(e_edges, 8), bit'(lock_n >= 16),
            ce_of(e_edges, 3), clk_of(e_edges, 3), bit'(lock_n >= 5),
            ce_of(e_edges, 1), clk_of(e_edges, 1), bit'(lock_n >= 1),
            qe, qe, qe};
  endfunction

  function automatic logic [11:0] gotv();
    return {ce8, clk8, lk8, ce3, clk3, lk3, ce1, clk1, lk1, q8, q3, q1};
  endfunction

  task automatic to_hi();
    @(posedge CLK); #2;
  endtask

  task automatic to_lo();
    @(negedge CLK); #2;
  endtask

  task automatic rand_ddr();
    D1 = 1'($urandom_range(0, 1));
    D2 = 1'($urandom_range(0, 1));
    DDR_CE = ($urandom_range(0, 3) != 0);
    DDR_R = ($urandom_range(0, 9) == 0);
    DDR_S = ($urandom_range(0, 9) == 0);
  endtask

  task automatic test_reset();
    to_hi();
    n_cmp++;
    if (gotv() !== 12'h000) begin
      n_bad++; $display("FAIL reset_hi got %b exp %b", gotv(), 12'h000);
    end
    to_lo();
    n_cmp++;
    if (gotv() !== 12'h000) begin
      n_bad++; $display("FAIL reset_lo got %b exp %b", gotv(), 12'h000);
    end
    RST_N = 1'b1;
    $display("test_reset done: outputs low in reset, released");
  endtask

  task automatic test_divider();
    for (int k = 1; k <= 40; k++) begin
      rand_ddr();
      to_hi();
      n_cmp++;
      if (gotv() !== expv(1'b1)) begin
        n_bad++; $display("FAIL div_hi edge %0d got %b exp %b", k, gotv(), expv(1'b1));
      end
      n_cmp++;
      if (lk8 !== (k >= 16)) begin
        n_bad++; $display("FAIL locked16 edge %0d got %b exp %b", k, lk8, k >= 16);
      end
      to_lo();
      n_cmp++;
      if (gotv() !== expv(1'b0)) begin
        n_bad++; $display("FAIL div_lo edge %0d got %b exp %b", k, gotv(), expv(1'b0));
      end
    end
    $display("test_divider done: 40 edges after reset release");
  endtask

  task automatic test_div_clr();
    int tries = 0;
    while ((e_edges % 8) != 5 && tries < 16) begin
      to_hi(); to_lo(); tries++;
    end
    n_cmp++;
    if ((e_edges % 8) != 5) begin
      n_bad++; $display("FAIL clr_search got cnt %0d exp 5", e_edges % 8);
    end
    DIV_CLR = 1'b1;
    to_hi();
    n_cmp++;
    if ({ce8, clk8} !== 2'b00) begin
      n_bad++; $display("FAIL clr_edge got ce/clock %b exp 00", {ce8, clk8});
    end
    to_lo();
    DIV_CLR = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      to_hi();
      n_cmp++;
      if (ce8 !== (k == 8)) begin
        n_bad++; $display("FAIL clr_next_ce edge %0d got %b exp %b", k, ce8, k == 8);
      end
      n_cmp++;
      if (gotv() !== expv(1'b1)) begin
        n_bad++; $display("FAIL clr_hi edge %0d got %b exp %b", k, gotv(), expv(1'b1));
      end
      to_lo();
    end
    for (int k = 0; k < 60; k++) begin
      DIV_CLR = ($urandom_range(0, 5) == 0);
      rand_ddr();
      to_hi();
      n_cmp++;
      if (gotv() !== expv(1'b1)) begin
        n_bad++; $display("FAIL rclr_hi step %0d got %b exp %b", k, gotv(), expv(1'b1));
      end
      to_lo();
      n_cmp++;
      if (gotv() !== expv(1'b0)) begin
        n_bad++; $display("FAIL rclr_lo step %0d got %b exp %b", k, gotv(), expv(1'b0));
      end
    end
    DIV_CLR = 1'b0;
    $display("test_div_clr done: directed clear at cnt 5 plus random clears");
  endtask

  task automatic test_ddr_patterns();
    // {D1, D2, DDR_CE, DDR_R, DDR_S, Q in high phase, Q in low phase}
    logic [6:0] rows [8];
    rows = '{7'b10100_10, 7'b00100_00, 7'b11100_11, 7'b11111_00,
             7'b00001_11, 7'b10100_10, 7'b01000_10, 7'b01000_10};
    for (int r = 0; r < 8; r++) begin
      {D1, D2, DDR_CE, DDR_R, DDR_S} = rows[r][6:2];
      for (int rep = 0; rep < 2; rep++) begin
        to_hi();
        n_cmp++;
        if (q8 !== rows[r][1]) begin
          n_bad++; $display("FAIL ddr_row%0d_hi got %b exp %b", r, q8, rows[r][1]);
        end
        to_lo();
        n_cmp++;
        if (q8 !== rows[r][0]) begin
          n_bad++; $display("FAIL ddr_row%0d_lo got %b exp %b", r, q8, rows[r][0]);
        end
      end
      $display("ddr row %0d: D1=%b D2=%b CE=%b R=%b S=%b -> Q %b/%b",
               r, D1, D2, DDR_CE, DDR_R, DDR_S, rows[r][1], rows[r][0]);
    end
    for (int k = 0; k < 80; k++) begin
      rand_ddr();
      to_hi();
      n_cmp++;
      if (gotv() !== expv(1'b1)) begin
        n_bad++; $display("FAIL rddr_hi step %0d got %b exp %b", k, gotv(), expv(1'b1));
      end
      to_lo();
      n_cmp++;
      if (gotv() !== expv(1'b0)) begin
        n_bad++; $display("FAIL rddr_lo step %0d got %b exp %b", k, gotv(), expv(1'b0));
      end
    end
    {DDR_R, DDR_S} = 2'b00;
    $display("test_ddr_patterns done");
  endtask

  task automatic test_async_reset();
    {D1, D2, DDR_CE} = 3'b111;
    to_hi();
    #1 RST_N = 1'b0;
    #1;
    n_cmp++;
    if (gotv() !== 12'h000 || CLK !== 1'b1) begin
      n_bad++; $display("FAIL async_reset got %b exp %b", gotv(), 12'h000);
    end
    to_lo();
    RST_N = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      rand_ddr();
      to_hi();
      n_cmp++;
      if (lk8 !== (k >= 16)) begin
        n_bad++; $display("FAIL relock edge %0d got %b exp %b", k, lk8, k >= 16);
      end
      n_cmp++;
      if (gotv() !== expv(1'b1)) begin
        n_bad++; $display("FAIL rst_hi edge %0d got %b exp %b", k, gotv(), expv(1'b1));
      end
      to_lo();
    end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_divider();
    test_div_clr();
    test_ddr_patterns();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
